vpu_req_arb: RTL

- Round-robin request arbiter and sequencer in front of the single VPU request port.
- Accepts operation requests from NUM_REQ hosts and issues one operation at a time to the VPU.
- Holds that operation until the VPU signals completion, then returns a tagged completion response to the owning host.
- Rejects illegal opcodes locally, without issuing them to the VPU.

---
 rtl/vpu_req_arb.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vpu_req_arb.sv
//==============================================================================
// Module      : vpu_req_arb
// Description : Round-robin arbiter/sequencer feeding the single VPU request
//               port; one operation in flight, tagged completion response.
//               Optional busy watchdog enabled by defining VPU_ARB_WDT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module vpu_req_arb #(
    parameter int NUM_REQ    = 4,
    parameter int OPC_W      = 5,
    parameter int OPC_NUM    = 23,
    parameter int AW         = 32,
    parameter int WDT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*OPC_W-1:0]   req_opcode_i,
    input  logic [NUM_REQ*AW-1:0]      req_src0_addr_i,
    input  logic [NUM_REQ*AW-1:0]      req_src1_addr_i,
    input  logic [NUM_REQ*AW-1:0]      req_dst_addr_i,
    output logic                       vpu_valid_o,
    input  logic                       vpu_ready_i,
    output logic [OPC_W-1:0]           vpu_opcode_o,
    output logic [AW-1:0]              vpu_src0_addr_o,
    output logic [AW-1:0]              vpu_src1_addr_o,
    output logic [AW-1:0]              vpu_dst_addr_o,
    input  logic                       vpu_done_i,
    output logic                       rsp_valid_o,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
    output logic                       rsp_err_o,
    output logic                       busy_o,
    output logic [15:0]                op_cnt_o
);

    localparam int c_id_w = $clog2(NUM_REQ);
    // One extra bit so OPC_NUM == 2**OPC_W still compares correctly.
    localparam logic [OPC_W:0] c_opc_num = (OPC_W + 1)'(OPC_NUM);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_busy  = 2'd2;
    localparam logic [1:0] c_st_resp  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_id_w-1:0] r_last_grant;
    logic [c_id_w-1:0] r_gnt_id;
    logic [c_id_w-1:0] r_rsp_id;
    logic              r_rsp_err;
    logic [OPC_W-1:0]  r_opcode;
    logic [AW-1:0]     r_src0;
    logic [AW-1:0]     r_src1;
    logic [AW-1:0]     r_dst;
    logic [15:0]       r_op_cnt;
    logic              w_any;
    logic [c_id_w-1:0] w_grant;
    logic [OPC_W-1:0]  w_opc;
    logic              w_legal;
    logic              w_timeout;

    // Descending scan so the nearest index after last_grant is written last.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_valid_i[(int'(r_last_grant) + i) % NUM_REQ]) begin
                w_any   = 1'b1;
                w_grant = c_id_w'((int'(r_last_grant) + i) % NUM_REQ);
            end
        end
    end

    assign w_opc   = req_opcode_i[w_grant*OPC_W +: OPC_W];
    assign w_legal = ({1'b0, w_opc} < c_opc_num);

`ifdef VPU_ARB_WDT_EN
    localparam int c_wdt_w = $clog2(WDT_CYCLES + 1);
    logic [c_wdt_w-1:0] r_wdt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdt <= '0;
        end else if (r_state == c_st_busy) begin
            r_wdt <= r_wdt + 1'b1;
        end else begin
            r_wdt <= '0;
        end
    end

    assign w_timeout = (r_wdt == c_wdt_w'(WDT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = '0;
        vpu_valid_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_any) begin
                    req_ready_o[w_grant] = 1'b1;
                    w_state_nxt          = w_legal ? c_st_issue : c_st_resp;
                end
            end
            c_st_issue: begin
                vpu_valid_o = 1'b1;
                if (vpu_ready_i) w_state_nxt = c_st_busy;
            end
            c_st_busy: begin
                if (vpu_done_i || w_timeout) w_state_nxt = c_st_resp;
            end
            default: begin
                rsp_valid_o = 1'b1;
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Payload and response registers only move when they become meaningful,
    // so the outputs hold their last values while not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= c_id_w'(NUM_REQ - 1);
            r_gnt_id     <= '0;
            r_rsp_id     <= '0;
            r_rsp_err    <= 1'b0;
            r_opcode     <= '0;
            r_src0       <= '0;
            r_src1       <= '0;
            r_dst        <= '0;
            r_op_cnt     <= '0;
        end else begin
            if (r_state == c_st_idle && w_any) begin
                r_last_grant <= w_grant;
                r_gnt_id     <= w_grant;
                if (w_legal) begin
                    r_opcode <= w_opc;
                    r_src0   <= req_src0_addr_i[w_grant*AW +: AW];
                    r_src1   <= req_src1_addr_i[w_grant*AW +: AW];
                    r_dst    <= req_dst_addr_i[w_grant*AW +: AW];
                end else begin
                    r_rsp_id  <= w_grant;
                    r_rsp_err <= 1'b1;
                end
            end
            if (r_state == c_st_busy) begin
                if (vpu_done_i) begin
                    r_rsp_id  <= r_gnt_id;
                    r_rsp_err <= 1'b0;
                    r_op_cnt  <= r_op_cnt + 16'd1;
                end else if (w_timeout) begin
                    r_rsp_id  <= r_gnt_id;
                    r_rsp_err <= 1'b1;
                end
            end
        end
    end

    assign vpu_opcode_o    = r_opcode;
    assign vpu_src0_addr_o = r_src0;
    assign vpu_src1_addr_o = r_src1;
    assign vpu_dst_addr_o  = r_dst;
    assign rsp_id_o        = r_rsp_id;
    assign rsp_err_o       = r_rsp_err;
    assign busy_o          = (r_state != c_st_idle);
    assign op_cnt_o        = r_op_cnt;

endmodule

`default_nettype wire
